// File: rtl/dds_pkg.sv
// Shared constants and elaboration-time sine table generator for the DDS carrier.
// Phase-dither LFSR constants exist only when DDS_PHASE_DITHER_EN is defined.
package dds_pkg;

    localparam int  DW_DEF = 12;
    localparam int  FW     = DW_DEF - 1;
    localparam int  QW     = 2;
    localparam real PI     = 3.14159265358979323846;

`ifdef DDS_PHASE_DITHER_EN
    // Right-shift Galois form of x^16+x^14+x^13+x^11+1
    localparam logic [15:0] LFSR_POLY = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
`endif

    // Half-LSB phase offset makes the quarter wave exactly mirror-symmetric
    function automatic int sine_q(input int k, input int fw, input int lw);
        real x;
        x = (PI / 2.0) * (real'(k) + 0.5) / real'(1 << lw);
        return $rtoi(real'((1 << fw) - 1) * $sin(x) + 0.5);
    endfunction

endpackage

// File: rtl/dds_sine_rom.sv
// Registered quarter-wave sine ROM, 2^LW entries of DW-1 unsigned bits.
// One enabled cycle of latency; holds its output while en is low.
module dds_sine_rom
    import dds_pkg::*;
#(
    parameter int DW = 12,
    parameter int LW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [LW-1:0] addr_i,
    output logic [DW-2:0] data_o
);

    logic [DW-2:0] rom [2**LW];
    logic [DW-2:0] data_q;
    logic [DW-2:0] data_d;

    for (genvar k = 0; k < 2**LW; k++) begin : g_rom
        assign rom[k] = (DW-1)'(sine_q(k, DW-1, LW));
    end

    always_comb begin
        data_d = rom[addr_i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else if (en) begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/dds_carrier_gen.sv
// Phase-accumulator DDS carrier: 4-stage pipeline, signed Q1.FW output, stalls on en=0.
// Optional phase dither under DDS_PHASE_DITHER_EN.
module dds_carrier_gen
    import dds_pkg::*;
#(
    parameter int DW = FW + 1,
    parameter int PW = 32,
    parameter int LW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [PW-1:0] ftw,
    input  logic          ftw_load,
    input  logic [PW-1:0] phase_off,
    output logic [DW-1:0] carr,
    output logic          carr_vld,
    output logic          wrap
);

    localparam int SH = PW - QW - LW;

    logic [PW-1:0]    ftw_shadow_q, ftw_shadow_d;
    logic [PW-1:0]    ftw_active_q, ftw_active_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic             wrap_s1_q, wrap_s1_d;
    logic [PW-1:0]    p_sum;
    logic [QW+LW-1:0] p_top;
    logic [LW-1:0]    addr_s2_q, addr_s2_d;
    logic             neg_s2_q, neg_s2_d;
    logic             wrap_s2_q;
    logic             neg_s3_q;
    logic             wrap_s3_q;
    logic [DW-2:0]    lut_s3;
    logic [DW-1:0]    mag;
    logic [DW-1:0]    carr_q, carr_d;
    logic             wrap_q;
    logic [3:0]       vld_q, vld_d;

`ifdef DDS_PHASE_DITHER_EN
    localparam int DB = (SH < 16) ? SH : 16;
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_POLY) : (lfsr_q >> 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else if (en) begin
            lfsr_q <= lfsr_d;
        end
    end

    // Dither lands below the LUT address bits, before truncation
    assign p_sum = acc_q + phase_off + PW'(lfsr_q[DB-1:0]);
`else
    assign p_sum = acc_q + phase_off;
`endif

    always_comb begin
        ftw_shadow_d = ftw_load ? ftw : ftw_shadow_q;
        // Active word refreshes ahead of the accumulate, so a load only ever swaps rate between samples
        ftw_active_d = en ? ftw_shadow_q : ftw_active_q;
        {wrap_s1_d, acc_d} = {1'b0, acc_q} + {1'b0, ftw_active_d};

        p_top     = (QW+LW)'(p_sum >> SH);
        addr_s2_d = p_top[QW+LW-2] ? ~p_top[LW-1:0] : p_top[LW-1:0];
        neg_s2_d  = p_top[QW+LW-1];

        mag    = {1'b0, lut_s3};
        carr_d = neg_s3_q ? -mag : mag;
        vld_d  = {vld_q[2:0], 1'b1};
    end

    dds_sine_rom #(
        .DW (DW),
        .LW (LW)
    ) u_rom (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .addr_i (addr_s2_q),
        .data_o (lut_s3)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ftw_shadow_q <= '0;
            ftw_active_q <= '0;
            acc_q        <= '0;
            wrap_s1_q    <= 1'b0;
            addr_s2_q    <= '0;
            neg_s2_q     <= 1'b0;
            wrap_s2_q    <= 1'b0;
            neg_s3_q     <= 1'b0;
            wrap_s3_q    <= 1'b0;
            carr_q       <= '0;
            wrap_q       <= 1'b0;
            vld_q        <= '0;
        end else begin
            ftw_shadow_q <= ftw_shadow_d;
            if (en) begin
                ftw_active_q <= ftw_active_d;
                acc_q        <= acc_d;
                wrap_s1_q    <= wrap_s1_d;
                addr_s2_q    <= addr_s2_d;
                neg_s2_q     <= neg_s2_d;
                wrap_s2_q    <= wrap_s1_q;
                neg_s3_q     <= neg_s2_q;
                wrap_s3_q    <= wrap_s2_q;
                carr_q       <= carr_d;
                wrap_q       <= wrap_s3_q;
                vld_q        <= vld_d;
            end
        end
    end

    assign carr     = carr_q;
    assign carr_vld = vld_q[3];
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_dds_carrier_gen.sv
// Directed and randomized bench for dds_carrier_gen against an angle-based sine reference model.
module tb_dds_carrier_gen;

    localparam real PI = 3.14159265358979323846;

    logic        clk = 1'b0;
    logic        rst, en, ftw_load;
    logic [31:0] ftw, phase_off;
    logic [11:0] carr;
    logic        carr_vld, wrap;

    always #5 clk = ~clk;

    dds_carrier_gen #(.DW(12), .PW(32), .LW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .ftw       (ftw),
        .ftw_load  (ftw_load),
        .phase_off (phase_off),
        .carr      (carr),
        .carr_vld  (carr_vld),
        .wrap      (wrap)
    );

    int errors = 0;
    int checks = 0;

    // Reference state: accumulator, tuning words and samples in flight
    logic [31:0] m_acc, m_shadow, m_active;
    int          q_carr[$];
    bit          q_wrap[$];
    int          m_carr;
    bit          m_wrap, m_vld;
    int          rec[$];
    int          rec_wrap;
    int          base[256];

    // Sample value taken from the truncated phase angle, centred in its LUT bin
    function automatic int ref_sample(input logic [31:0] p);
        real s;
        int  m;
        s = $sin(2.0 * PI * (real'(p >> 22) + 0.5) / 1024.0);
        m = $rtoi(2047.0 * ((s < 0.0) ? -s : s) + 0.5);
        return (s < 0.0) ? -m : m;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [32:0] sum;
        if (rst) begin
            m_acc = 0; m_shadow = 0; m_active = 0;
            q_carr.delete(); q_wrap.delete();
            m_carr = 0; m_wrap = 0; m_vld = 0;
        end else begin
            if (en) begin
                m_active = m_shadow;
                sum      = {1'b0, m_acc} + {1'b0, m_active};
                m_acc    = sum[31:0];
                q_carr.push_back(ref_sample(m_acc + phase_off));
                q_wrap.push_back(sum[32]);
                if (q_carr.size() == 4) begin
                    m_carr = q_carr.pop_front();
                    m_wrap = q_wrap.pop_front();
                    m_vld  = 1'b1;
                end
            end
            if (ftw_load) m_shadow = ftw;
        end
        @(posedge clk);
        #1;
        check("carr_vld", int'(carr_vld), int'(m_vld));
        check("wrap", int'(wrap), int'(m_wrap));
        if (m_vld || rst) check("carr", int'($signed(carr)), m_carr);
        if (!rst && en && m_vld) begin
            rec.push_back(int'($signed(carr)));
            rec_wrap += int'(wrap);
        end
    endtask

    // Reset, load 2^24, then gather 256 valid samples with en steady or random
    task automatic run_ref(input bit rand_en);
        rst = 1; en = 0; ftw_load = 0; phase_off = 0;
        tick();
        rst = 0; ftw = 32'h0100_0000; ftw_load = 1;
        tick();
        ftw_load = 0;
        rec.delete();
        rec_wrap = 0;
        for (int i = 0; i < 2000 && rec.size() < 256; i++) begin
            en = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
        end
        check("rec_len", rec.size(), 256);
    endtask

    initial begin
        int mx, mn, sum, bad;

        rst = 1; en = 0; ftw_load = 0; ftw = 0; phase_off = 0;
        tick();
        tick();

        // Constant output at zero phase, valid on 4th enabled cycle
        rst = 0; en = 1;
        repeat (3) tick();
        check("vld_before_4th", int'(carr_vld), 0);
        tick();
        check("vld_at_4th", int'(carr_vld), 1);
        check("lut0", int'($signed(carr)), 6);
        repeat (5) tick();
        check("lut0_hold", int'($signed(carr)), 6);

        // Quarter and three-quarter offsets give the peaks
        rst = 1; phase_off = 32'h4000_0000;
        tick();
        rst = 0;
        repeat (8) tick();
        check("pos_peak", int'($signed(carr)), 2047);
        rst = 1; phase_off = 32'hC000_0000;
        tick();
        rst = 0;
        repeat (8) tick();
        check("neg_peak", int'($signed(carr)), -2047);

        // One full period at 2^24
        run_ref(1'b0);
        mx = -5000; mn = 5000; sum = 0; bad = 0;
        for (int i = 0; i < 256; i++) begin
            base[i] = (i < rec.size()) ? rec[i] : 0;
            if (base[i] > mx) mx = base[i];
            if (base[i] < mn) mn = base[i];
            sum += base[i];
        end
        for (int i = 0; i < 128; i++) if (base[i] != -base[i+128]) bad++;
        check("period_max", mx, 2047);
        check("period_min", mn, -2047);
        check("period_sum", sum, 0);
        check("half_antisym", bad, 0);
        check("wraps_per_period", rec_wrap, 1);

        // Random stalls must not lose or repeat samples
        run_ref(1'b1);
        bad = 0;
        for (int i = 0; i < 256; i++) if (i >= rec.size() || rec[i] != base[i]) bad++;
        check("stall_seq", bad, 0);

        // Rate change mid-stream with en held high
        en = 1; ftw = 32'h0200_0000; ftw_load = 1;
        tick();
        ftw_load = 0;
        repeat (300) tick();

        // Reset pulse mid-stream, then identical restart
        rst = 1;
        tick();
        check("rst_carr", int'($signed(carr)), 0);
        check("rst_vld", int'(carr_vld), 0);
        check("rst_wrap", int'(wrap), 0);
        rst = 0;
        run_ref(1'b0);
        bad = 0;
        for (int i = 0; i < 256; i++) if (i >= rec.size() || rec[i] != base[i]) bad++;
        check("restart_seq", bad, 0);

        // Random offsets, rates, loads and stalls
        for (int r = 0; r < 3; r++) begin
            rst = 1; en = 0; ftw_load = 0; phase_off = $urandom;
            tick();
            rst = 0;
            for (int i = 0; i < 400; i++) begin
                en       = 1'($urandom_range(0, 1));
                ftw_load = ($urandom_range(0, 49) == 0);
                ftw      = $urandom;
                tick();
            end
            ftw_load = 0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dds_carrier_gen.md
Name: dds_carrier_gen

Overview:
- Phase-accumulator DDS that generates the sinusoidal carrier consumed by the AM modulator's `carr` input.
- Output is signed Q1.FW, DW bits, one sample per enabled clock.
- Shares `clk`/`rst`/`en` with the modulator, so samples stay aligned when the chain stalls.
- Frequency and phase are runtime-programmable. Frequency updates are glitch-free.

Parameters:
- DW, 12, output sample width (Q1.FW, FW = DW-1)
- PW, 32, phase accumulator width
- LW, 8, quarter-wave LUT address width (2^LW entries, each DW-1 bits unsigned)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- en  in  1  clock enable; stalls the whole pipeline when low
- ftw  in  PW  frequency tuning word (unsigned)
- ftw_load  in  1  pulse; captures ftw into the shadow register
- phase_off  in  PW  static phase offset (unsigned, full circle = 2^PW)
- carr  out  DW  signed carrier sample, Q1.FW
- carr_vld  out  1  high when carr holds a valid sample
- wrap  out  1  one-cycle pulse, aligned with carr, on the sample where the accumulator overflowed

Behaviour:
- Reset: acc, ftw_shadow and ftw_active are cleared to 0; all pipeline registers are cleared; carr=0, carr_vld=0, wrap=0.
- Reset wins over en and ftw_load in the same cycle. Reset mid-operation restarts phase at 0.
- ftw_load:
  - Loads ftw_shadow on any cycle, regardless of en.
  - ftw_active <= ftw_shadow on the next cycle with en=1, before that cycle's accumulate.
  - The new frequency therefore first affects the accumulate one enabled cycle after the load is seen.
  - Back-to-back loads: the last one wins.
- Stage 1 (en=1): acc <= acc + ftw_active, modulo 2^PW; the carry-out is registered as wrap_s1.
- Stage 2: p = acc + phase_off (mod 2^PW).
  - q = p[PW-1:PW-2] (quadrant).
  - a = p[PW-3:PW-2-LW] (LUT address).
  - Address is a when q[0]=0, else ~a (mirror). Negate flag = q[1].
- Stage 3: registered LUT read.
  - lut[k] = round((2^FW-1) * sin(pi/2 * (k+0.5) / 2^LW)).
  - The half-LSB offset gives exact mirror symmetry. Maximum is 2^FW-1, so no output ever equals -2^FW.
- Stage 4: carr <= negate ? -{1'b0,lut} : {1'b0,lut}.
- carr_vld is a 4-deep shift register fed with 1 when en=1. It goes high on the 4th enabled cycle after reset release.
- wrap is delayed alongside the data.
- Latency: 4 enabled cycles from the accumulator update to carr.
- en=0 freezes every register except ftw_shadow. No sample is lost or duplicated.
- ftw=0 gives a constant output at phase_off. ftw >= 2^(PW-1) aliases, which is legal: the output is the mirrored frequency.
- Phase truncation: the low PW-2-LW bits are discarded unless dither is enabled.

Optional Feature:
- Macro DDS_PHASE_DITHER_EN.
- Defined:
  - A 16-bit Galois LFSR (polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset) advances on each enabled cycle.
  - Its low min(16, PW-2-LW) bits are added to p in stage 2, below the LUT address bits, before truncation.
  - This spreads phase-truncation spurs. Latency is unchanged.
- Undefined: no LFSR, and p is truncated directly.

Decomposition:
- Package dds_pkg:
  - localparams FW and QW = 2.
  - LUT generation function `sine_q(k)` for elaboration-time ROM init.
  - LFSR polynomial and seed constants.
- One sub-module, `dds_sine_rom`: a registered quarter-wave ROM, parameterised by DW and LW, initialised from dds_pkg.
- Accumulator, quadrant logic and negation stay in the top module.

Test Plan:
All cases use DW=12, PW=32, LW=8, dither off.
1. Reset then en=1, ftw=0, phase_off=0 -> carr_vld rises on the 4th enabled cycle, then carr is constant +6 (lut[0]).
2. ftw=0, phase_off=32'h4000_0000 -> constant carr=+2047. phase_off=32'hC000_0000 -> constant -2047.
3. ftw_load with ftw=32'h0100_0000 -> period of 256 samples, wrap once every 256 enabled cycles. Across one period: max=2047, min=-2047, sum=0, and sample n equals the negation of sample n+128.
4. Toggle en randomly at 50% with ftw=32'h0100_0000 -> the sequence of carr values on valid enabled cycles is identical to the en=1 run of case 3.
5. Change ftw from 32'h0100_0000 to 32'h0200_0000 mid-stream with en high -> no phase discontinuity. Sample-to-sample phase step doubles exactly 4 enabled cycles after the first new-rate accumulate.
6. Assert rst for 1 cycle during streaming -> the next cycle shows carr=0, carr_vld=0, wrap=0, and the sequence restarts identically to case 3. With DDS_PHASE_DITHER_EN defined and ftw=32'h0123_4567, the spur level is below the undithered run.
